// File: rtl/alu_task_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_task_arbiter
// Brief    : Round-robin arbiter that shares one ALU controller between
//            NUM_REQ requesters. It issues one task at a time, captures the
//            single-cycle result pulse and returns it to the granted
//            requester. Illegal opcodes and result timeouts are reported
//            through an error flag on the response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_task_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int ALU_OPP_WIDTH = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    // task channels, one per requester
    input  logic [NUM_REQ-1:0]               s_req_tvalid,
    output logic [NUM_REQ-1:0]               s_req_tready,
    input  logic [NUM_REQ*ALU_OPP_WIDTH-1:0] s_req_opp,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_req_b,
    // response channels, data and error shared by all requesters
    output logic [NUM_REQ-1:0]               m_resp_tvalid,
    input  logic [NUM_REQ-1:0]               m_resp_tready,
    output logic [DATA_WIDTH-1:0]            m_resp_tdata,
    output logic                             m_resp_terr,
    // ALU controller side
    output logic [ALU_OPP_WIDTH-1:0]         alu_opp,
    output logic [DATA_WIDTH-1:0]            alu_a_tdata,
    output logic [DATA_WIDTH-1:0]            alu_b_tdata,
    output logic                             alu_a_tvalid,
    input  logic                             alu_a_tready,
    input  logic [DATA_WIDTH-1:0]            alu_result_tdata,
    input  logic                             alu_result_tvalid,
    // status
    output logic                             busy
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [c_IDX_W:0]         c_NREQ      = (c_IDX_W + 1)'(NUM_REQ);
    localparam logic [c_IDX_W-1:0]       c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_TMR_W-1:0]       c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);
    localparam logic [ALU_OPP_WIDTH-1:0] c_OPP_DIV   = ALU_OPP_WIDTH'(2);
    localparam logic [NUM_REQ-1:0]       c_ONE       = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        RESPOND  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [NUM_REQ-1:0]        r_req_tready;
    logic [c_IDX_W-1:0]        r_win;       // requester currently offered tready
    logic [c_IDX_W-1:0]        r_grant;     // requester owning the task in flight
    logic [c_IDX_W-1:0]        r_rr_ptr;
    logic [c_TMR_W-1:0]        r_timer;

    logic [ALU_OPP_WIDTH-1:0]  r_alu_opp;
    logic [DATA_WIDTH-1:0]     r_alu_a;
    logic [DATA_WIDTH-1:0]     r_alu_b;
    logic                      r_alu_a_tvalid;

    logic [NUM_REQ-1:0]        r_resp_tvalid;
    logic [DATA_WIDTH-1:0]     r_resp_tdata;
    logic                      r_resp_terr;

    logic [c_IDX_W:0]          w_cand;
    logic [c_IDX_W-1:0]        w_win;
    logic [c_IDX_W-1:0]        w_rr_nxt;
    logic [ALU_OPP_WIDTH-1:0]  w_opp_sel;
    logic [DATA_WIDTH-1:0]     w_a_sel;
    logic [DATA_WIDTH-1:0]     w_b_sel;
    logic                      w_opp_legal;

    logic                      w_pick;
    logic                      w_grant_hs;
    logic                      w_issue_hs;
    logic                      w_res_take;
    logic                      w_timeout;
    logic                      w_wait_tick;
    logic                      w_resp_hs;

    // Round-robin search: scan offsets from the highest down so the lowest
    // offset from r_rr_ptr with a valid request is the final winner.
    always_comb begin
        w_win  = r_rr_ptr;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_cand >= c_NREQ) begin
                w_cand = w_cand - c_NREQ;
            end
            if (s_req_tvalid[w_cand[c_IDX_W-1:0]]) begin
                w_win = w_cand[c_IDX_W-1:0];
            end
        end
    end

    // Task fields of the requester being offered tready, plus the pointer
    // value that follows it.
    assign w_opp_sel   = s_req_opp[int'(r_win)*ALU_OPP_WIDTH +: ALU_OPP_WIDTH];
    assign w_a_sel     = s_req_a[int'(r_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_b_sel     = s_req_b[int'(r_win)*DATA_WIDTH +: DATA_WIDTH];
    assign w_opp_legal = (w_opp_sel <= c_OPP_DIV);
    assign w_rr_nxt    = (r_win == c_LAST_IDX) ? '0 : r_win + 1'b1;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the per-state event strobes used by the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_pick      = 1'b0;
        w_grant_hs  = 1'b0;
        w_issue_hs  = 1'b0;
        w_res_take  = 1'b0;
        w_timeout   = 1'b0;
        w_wait_tick = 1'b0;
        w_resp_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                // tready is raised one cycle after the search, so the search
                // only runs while no offer is outstanding.
                w_pick     = (r_req_tready == '0) && (|s_req_tvalid);
                w_grant_hs = |(r_req_tready & s_req_tvalid);
                if (w_grant_hs) begin
                    w_state_nxt = w_opp_legal ? ISSUE : RESPOND;
                end
            end
            ISSUE: begin
                w_issue_hs = r_alu_a_tvalid && alu_a_tready;
                if (w_issue_hs) begin
                    w_state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // A result arriving on the last timer cycle still wins.
                w_res_take  = alu_result_tvalid;
                w_timeout   = !alu_result_tvalid && (r_timer == c_TMR_LAST);
                w_wait_tick = !w_res_take && !w_timeout;
                if (w_res_take || w_timeout) begin
                    w_state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                // Only the granted bit of m_resp_tready matters, since the
                // valid vector is one-hot on the grant.
                w_resp_hs = |(r_resp_tvalid & m_resp_tready);
                if (w_resp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: task capture, controller handshake, timer and response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req_tready   <= '0;
            r_win          <= '0;
            r_grant        <= '0;
            r_rr_ptr       <= '0;
            r_timer        <= '0;
            r_alu_opp      <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_a_tvalid <= 1'b0;
            r_resp_tvalid  <= '0;
            r_resp_tdata   <= '0;
            r_resp_terr    <= 1'b0;
        end else begin
            r_req_tready <= w_pick ? (c_ONE << w_win) : '0;
            if (w_pick) begin
                r_win <= w_win;
            end

            if (w_grant_hs) begin
                r_alu_opp <= w_opp_sel;
                r_alu_a   <= w_a_sel;
                r_alu_b   <= w_b_sel;
                r_grant   <= r_win;
                r_rr_ptr  <= w_rr_nxt;
                if (w_opp_legal) begin
                    r_alu_a_tvalid <= 1'b1;
                end else begin
                    // Illegal opcode: answer at once, controller untouched.
                    r_resp_tvalid <= c_ONE << r_win;
                    r_resp_tdata  <= '0;
                    r_resp_terr   <= 1'b1;
                end
            end

            if (w_issue_hs) begin
                r_alu_a_tvalid <= 1'b0;
                r_timer        <= '0;
            end

            if (w_wait_tick) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_res_take) begin
                r_resp_tvalid <= c_ONE << r_grant;
                r_resp_tdata  <= alu_result_tdata;
                r_resp_terr   <= 1'b0;
            end

            if (w_timeout) begin
                r_resp_tvalid <= c_ONE << r_grant;
                r_resp_tdata  <= '0;
                r_resp_terr   <= 1'b1;
            end

            if (w_resp_hs) begin
                r_resp_tvalid <= '0;
                r_resp_terr   <= 1'b0;
            end
        end
    end

    assign s_req_tready  = r_req_tready;
    assign m_resp_tvalid = r_resp_tvalid;
    assign m_resp_tdata  = r_resp_tdata;
    assign m_resp_terr   = r_resp_terr;
    assign alu_opp       = r_alu_opp;
    assign alu_a_tdata   = r_alu_a;
    assign alu_b_tdata   = r_alu_b;
    assign alu_a_tvalid  = r_alu_a_tvalid;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_task_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_task_arbiter
// Brief    : Directed, table-driven self-checking bench for alu_task_arbiter
//            with a behavioural ALU controller stub of adjustable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_task_arbiter;

    localparam int c_NR = 4;
    localparam int c_DW = 64;
    localparam int c_OW = 2;
    localparam int c_TO = 16;

    logic                   aclk;
    logic                   aresetn;
    logic [c_NR-1:0]        s_req_tvalid;
    logic [c_NR-1:0]        s_req_tready;
    logic [c_NR*c_OW-1:0]   s_req_opp;
    logic [c_NR*c_DW-1:0]   s_req_a;
    logic [c_NR*c_DW-1:0]   s_req_b;
    logic [c_NR-1:0]        m_resp_tvalid;
    logic [c_NR-1:0]        m_resp_tready;
    logic [c_DW-1:0]        m_resp_tdata;
    logic                   m_resp_terr;
    logic [c_OW-1:0]        alu_opp;
    logic [c_DW-1:0]        alu_a_tdata;
    logic [c_DW-1:0]        alu_b_tdata;
    logic                   alu_a_tvalid;
    logic                   alu_a_tready;
    logic [c_DW-1:0]        alu_result_tdata;
    logic                   alu_result_tvalid;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_issues = 0;

    alu_task_arbiter #(
        .NUM_REQ       (c_NR),
        .DATA_WIDTH    (c_DW),
        .ALU_OPP_WIDTH (c_OW),
        .TIMEOUT       (c_TO)
    ) u_dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .s_req_tvalid      (s_req_tvalid),
        .s_req_tready      (s_req_tready),
        .s_req_opp         (s_req_opp),
        .s_req_a           (s_req_a),
        .s_req_b           (s_req_b),
        .m_resp_tvalid     (m_resp_tvalid),
        .m_resp_tready     (m_resp_tready),
        .m_resp_tdata      (m_resp_tdata),
        .m_resp_terr       (m_resp_terr),
        .alu_opp           (alu_opp),
        .alu_a_tdata       (alu_a_tdata),
        .alu_b_tdata       (alu_b_tdata),
        .alu_a_tvalid      (alu_a_tvalid),
        .alu_a_tready      (alu_a_tready),
        .alu_result_tdata  (alu_result_tdata),
        .alu_result_tvalid (alu_result_tvalid),
        .busy              (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ------------------------------------------------------------------
    // ALU controller stub: accepts a task, pulses the result stub_lat
    // cycles later. This controller's DIV yields the remainder (100,7 -> 2).
    // ------------------------------------------------------------------
    int              stub_lat  = 3;
    bit              stub_mute = 1'b0;
    int              stub_cnt  = 0;
    int              issue_cnt = 0;
    logic [c_DW-1:0] stub_res  = '0;

    function automatic logic [c_DW-1:0] alu_model(input logic [c_OW-1:0] op,
                                                  input logic [c_DW-1:0] a,
                                                  input logic [c_DW-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a * b;
            2'd2:    return (b != 0) ? a % b : '0;
            default: return '0;
        endcase
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stub_cnt          <= 0;
            alu_result_tvalid <= 1'b0;
            alu_result_tdata  <= '0;
        end else begin
            alu_result_tvalid <= 1'b0;
            if (alu_a_tvalid && alu_a_tready) begin
                stub_cnt  <= stub_lat;
                stub_res  <= alu_model(alu_opp, alu_a_tdata, alu_b_tdata);
                issue_cnt <= issue_cnt + 1;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1 && !stub_mute) begin
                    alu_result_tvalid <= 1'b1;
                    alu_result_tdata  <= stub_res;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_tready(output bit to);
        int n = 0;
        while (s_req_tready == '0 && n < 50) begin
            step();
            n++;
        end
        to = (s_req_tready == '0);
    endtask

    task automatic wait_resp(output bit to);
        int n = 0;
        while (m_resp_tvalid == '0 && n < 100) begin
            step();
            n++;
        end
        to = (m_resp_tvalid == '0);
    endtask

    task automatic drive_req(input int r, input logic [1:0] op,
                             input logic [63:0] a, input logic [63:0] b);
        s_req_opp[r*c_OW +: c_OW] = op;
        s_req_a[r*c_DW +: c_DW]   = a;
        s_req_b[r*c_DW +: c_DW]   = b;
        s_req_tvalid[r]           = 1'b1;
    endtask

    // Wait for the offer to requester r, complete the handshake, drop valid.
    task automatic grant_req(input int r, input string nm);
        bit to;
        logic [c_NR-1:0] oh;
        oh = c_NR'(1) << r;
        wait_tready(to);
        check({nm, "_tready_wait"}, to, 0);
        check({nm, "_grant"}, s_req_tready, oh);
        step();
        s_req_tvalid[r] = 1'b0;
    endtask

    task automatic resp_ack(input int r, input string nm);
        m_resp_tready[r] = 1'b1;
        step();
        m_resp_tready[r] = 1'b0;
        check({nm, "_resp_clear"}, m_resp_tvalid, 0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_handshakes"}, {s_req_tready, m_resp_tvalid}, 0);
        check({nm, "_resp_data"}, m_resp_tdata, 0);
        check({nm, "_alu_operands"}, alu_a_tdata | alu_b_tdata, 0);
        check({nm, "_ctl"}, {m_resp_terr, alu_opp, alu_a_tvalid, busy}, 0);
    endtask

    // per-requester task table used by run_batch
    logic [1:0]  rq_op  [c_NR];
    logic [63:0] rq_a   [c_NR];
    logic [63:0] rq_b   [c_NR];
    logic [63:0] rq_exp [c_NR];
    bit          rq_err [c_NR];

    // Raise all requesters in mask together; expect grants in order ord[].
    task automatic run_batch(input logic [c_NR-1:0] mask, input int ord[4],
                             input int n, input string nm);
        bit to;
        logic [c_NR-1:0] oh;
        m_resp_tready = '1;
        for (int i = 0; i < c_NR; i++) begin
            if (mask[i]) drive_req(i, rq_op[i], rq_a[i], rq_b[i]);
        end
        for (int k = 0; k < n; k++) begin
            int r;
            r  = ord[k];
            oh = c_NR'(1) << r;
            grant_req(r, nm);
            check({nm, "_issue"}, alu_a_tvalid, !rq_err[r]);
            if (!rq_err[r]) exp_issues++;
            wait_resp(to);
            check({nm, "_resp_wait"}, to, 0);
            check({nm, "_resp_valid"}, m_resp_tvalid, oh);
            check({nm, "_resp_data"}, m_resp_tdata, rq_exp[r]);
            check({nm, "_resp_err"}, m_resp_terr, rq_err[r]);
            step();
            check({nm, "_resp_clear"}, m_resp_tvalid, 0);
            check({nm, "_issue_count"}, issue_cnt, exp_issues);
        end
        m_resp_tready = '0;
    endtask

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          err;
        string       nm;
    } vec_t;

    vec_t vecs [5];

    // ------------------------------------------------------------------
    // main sequence
    // ------------------------------------------------------------------
    initial begin
        int ord [4];

        vecs[0] = '{req: 0, op: 2'd0, a: 64'd5,  b: 64'd7,  exp: 64'd12, err: 1'b0, nm: "sum_5_7"};
        vecs[1] = '{req: 2, op: 2'd1, a: 64'd6,  b: 64'd7,  exp: 64'd42, err: 1'b0, nm: "mult_6_7"};
        vecs[2] = '{req: 3, op: 2'd0, a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, exp: 64'd0, err: 1'b0, nm: "sum_wrap"};
        vecs[3] = '{req: 1, op: 2'd1, a: 64'h1_0000_0000, b: 64'd3, exp: 64'h3_0000_0000, err: 1'b0, nm: "mult_wide"};
        vecs[4] = '{req: 0, op: 2'd3, a: 64'd9,  b: 64'd9,  exp: 64'd0,  err: 1'b1, nm: "illegal_req0"};

        aresetn       = 1'b0;
        s_req_tvalid  = '0;
        s_req_opp     = '0;
        s_req_a       = '0;
        s_req_b       = '0;
        m_resp_tready = '0;
        alu_a_tready  = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check_all_zero("reset");
        aresetn = 1'b1;
        step();
        check_all_zero("idle");

        // round robin from a fresh pointer: MULT (i+2)*3
        for (int i = 0; i < c_NR; i++) begin
            rq_op[i]  = 2'd1;
            rq_a[i]   = 64'(i + 2);
            rq_b[i]   = 64'd3;
            rq_exp[i] = 64'((i + 2) * 3);
            rq_err[i] = 1'b0;
        end
        run_batch(4'hF, '{0, 1, 2, 3}, 4, "rr");

        // single-task vectors
        for (int j = 0; j < 5; j++) begin
            int r;
            r         = vecs[j].req;
            rq_op[r]  = vecs[j].op;
            rq_a[r]   = vecs[j].a;
            rq_b[r]   = vecs[j].b;
            rq_exp[r] = vecs[j].exp;
            rq_err[r] = vecs[j].err;
            ord       = '{default: 0};
            ord[0]    = r;
            run_batch(c_NR'(1) << r, ord, 1, vecs[j].nm);
        end

        // illegal opcode from req1 moves the pointer to 2
        rq_op[1] = 2'd3; rq_a[1] = 64'd11; rq_b[1] = 64'd22; rq_exp[1] = 64'd0; rq_err[1] = 1'b1;
        run_batch(4'b0010, '{1, 0, 0, 0}, 1, "illegal_req1");
        for (int i = 0; i < c_NR; i++) begin
            rq_op[i]  = 2'd1;
            rq_a[i]   = 64'(i + 2);
            rq_b[i]   = 64'd3;
            rq_exp[i] = 64'((i + 2) * 3);
            rq_err[i] = 1'b0;
        end
        run_batch(4'hF, '{2, 3, 0, 1}, 4, "rr_from2");

        // DIV with response backpressure for 10 cycles
        begin
            bit to;
            stub_lat = 3;
            m_resp_tready = 4'b1011;
            drive_req(2, 2'd2, 64'd100, 64'd7);
            grant_req(2, "div");
            check("div_issue", alu_a_tvalid, 1);
            exp_issues++;
            wait_resp(to);
            check("div_resp_wait", to, 0);
            for (int i = 0; i < 10; i++) begin
                check("div_bp_valid", m_resp_tvalid, 4'b0100);
                check("div_bp_data", m_resp_tdata, 64'd2);
                check("div_bp_err", m_resp_terr, 0);
                step();
            end
            m_resp_tready = 4'b1111;
            step();
            m_resp_tready = '0;
            check("div_resp_clear", m_resp_tvalid, 0);
            check("div_idle", busy, 0);
        end

        // timeout, with ISSUE first stalled far beyond TIMEOUT
        alu_a_tready = 1'b0;
        stub_mute    = 1'b1;
        drive_req(0, 2'd0, 64'd9, 64'd9);
        grant_req(0, "to");
        check("to_issue", alu_a_tvalid, 1);
        repeat (30) step();
        check("to_issue_hold", alu_a_tvalid, 1);
        check("to_issue_noresp", m_resp_tvalid, 0);
        check("to_issue_a", alu_a_tdata, 64'd9);
        check("to_issue_b", alu_b_tdata, 64'd9);
        check("to_issue_opp", alu_opp, 2'd0);
        alu_a_tready = 1'b1;
        step();
        exp_issues++;
        check("to_wait_entry", alu_a_tvalid, 0);
        repeat (15) step();
        check("to_early", m_resp_tvalid, 0);
        step();
        check("to_resp_valid", m_resp_tvalid, 4'b0001);
        check("to_resp_data", m_resp_tdata, 0);
        check("to_resp_err", m_resp_terr, 1);
        resp_ack(0, "to");

        // result pulse on the last timer cycle wins over the timeout
        stub_mute = 1'b0;
        stub_lat  = 15;
        drive_req(1, 2'd0, 64'd20, 64'd22);
        grant_req(1, "tlast");
        check("tlast_issue", alu_a_tvalid, 1);
        exp_issues++;
        step();
        check("tlast_wait_entry", alu_a_tvalid, 0);
        repeat (15) step();
        check("tlast_early", m_resp_tvalid, 0);
        step();
        check("tlast_resp_valid", m_resp_tvalid, 4'b0010);
        check("tlast_resp_data", m_resp_tdata, 64'd42);
        check("tlast_resp_err", m_resp_terr, 0);
        resp_ack(1, "tlast");

        // asynchronous reset in WAIT_RES drops the task
        stub_lat = 10;
        drive_req(1, 2'd0, 64'd3, 64'd3);
        grant_req(1, "rst_task");
        exp_issues++;
        repeat (3) step();
        check("rst_task_busy", busy, 1);
        #3;
        aresetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge aclk);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (15) step();
        check("rst_dropped_resp", m_resp_tvalid, 0);
        check("rst_dropped_busy", busy, 0);
        stub_lat = 3;
        rq_op[0] = 2'd0; rq_a[0] = 64'd3; rq_b[0] = 64'd4; rq_exp[0] = 64'd7; rq_err[0] = 1'b0;
        rq_op[3] = 2'd0; rq_a[3] = 64'd1; rq_b[3] = 64'd1; rq_exp[3] = 64'd2; rq_err[3] = 1'b0;
        run_batch(4'b1001, '{0, 3, 0, 0}, 2, "post_reset");

        check("issue_total", issue_cnt, exp_issues);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
